// File: rtl/lc4_nzp_cc_bank.sv
// Multi-context LC4 condition-code bank: per-thread NZP storage, branch evaluation, taken counter.
// Optional macro LC4_NZP_CC_BYPASS_EN forwards same-cycle write data to the read/branch path.
module lc4_nzp_cc_bank #(
    parameter int WIDTH   = 16,
    parameter int THREADS = 4,
    parameter int TID_W   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gwe,
    input  logic             wr_en,
    input  logic [TID_W-1:0] wr_tid,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             br_eval,
    input  logic [TID_W-1:0] rd_tid,
    input  logic [2:0]       br_mask,
    output logic [2:0]       nzp,
    output logic             cc_valid,
    output logic             br_taken,
    output logic [15:0]      taken_cnt
);

    function automatic logic [2:0] nzp_reduce(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            return 3'b100;
        end else if (v == {WIDTH{1'b0}}) begin
            return 3'b010;
        end else begin
            return 3'b001;
        end
    endfunction

    logic [2:0]  nzp_q   [THREADS];
    logic [2:0]  nzp_d   [THREADS];
    logic        valid_q [THREADS];
    logic        valid_d [THREADS];
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    logic [2:0]  wr_nzp_s;
    logic [2:0]  rd_nzp_s;
    logic        rd_valid_s;
    logic        rd_hit_s;

    assign wr_nzp_s = nzp_reduce(wr_data);

    // Read mux; ids beyond THREADS never match and so read as 000 / invalid.
    always_comb begin
        rd_nzp_s   = 3'b000;
        rd_valid_s = 1'b0;
        rd_hit_s   = 1'b0;
        for (int t = 0; t < THREADS; t++) begin
            if (rd_tid == TID_W'(t)) begin
                rd_nzp_s   = nzp_q[t];
                rd_valid_s = valid_q[t];
                rd_hit_s   = 1'b1;
            end else begin
                rd_hit_s   = rd_hit_s;
            end
        end
`ifdef LC4_NZP_CC_BYPASS_EN
        if (gwe && wr_en && rd_hit_s && (wr_tid == rd_tid)) begin
            rd_nzp_s   = wr_nzp_s;
            rd_valid_s = 1'b1;
        end else begin
            rd_valid_s = rd_valid_s;
        end
`endif
    end

    assign nzp       = rd_nzp_s;
    assign cc_valid  = rd_valid_s;
    assign br_taken  = br_eval & rd_valid_s & (|(br_mask & rd_nzp_s));
    assign taken_cnt = cnt_q;

    // Next-state: one context written per cycle, saturating taken counter, all gated by gwe.
    always_comb begin
        nzp_d   = nzp_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (gwe) begin
            for (int t = 0; t < THREADS; t++) begin
                if (wr_en && (wr_tid == TID_W'(t))) begin
                    nzp_d[t]   = wr_nzp_s;
                    valid_d[t] = 1'b1;
                end else begin
                    nzp_d[t]   = nzp_q[t];
                end
            end
            if (br_taken && (cnt_q != 16'hFFFF)) begin
                cnt_d = cnt_q + 16'd1;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers; reset overrides any concurrent write or count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < THREADS; t++) begin
                nzp_q[t]   <= 3'b000;
                valid_q[t] <= 1'b0;
            end
            cnt_q <= 16'd0;
        end else begin
            nzp_q   <= nzp_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_lc4_nzp_cc_bank.sv
// Directed self-checking bench for lc4_nzp_cc_bank (default 16-bit, 4 contexts).
module tb_lc4_nzp_cc_bank;

    logic        clk;
    logic        rst;
    logic        gwe;
    logic        wr_en;
    logic [1:0]  wr_tid;
    logic [15:0] wr_data;
    logic        br_eval;
    logic [1:0]  rd_tid;
    logic [2:0]  br_mask;
    logic [2:0]  nzp;
    logic        cc_valid;
    logic        br_taken;
    logic [15:0] taken_cnt;

    int vectors;
    int miscompares;
    int exp_cnt;

    lc4_nzp_cc_bank #(.WIDTH(16), .THREADS(4), .TID_W(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .gwe      (gwe),
        .wr_en    (wr_en),
        .wr_tid   (wr_tid),
        .wr_data  (wr_data),
        .br_eval  (br_eval),
        .rd_tid   (rd_tid),
        .br_mask  (br_mask),
        .nzp      (nzp),
        .cc_valid (cc_valid),
        .br_taken (br_taken),
        .taken_cnt(taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; gwe = 1'b0; wr_en = 1'b0; wr_tid = 2'd0; wr_data = 16'h0000;
        br_eval = 1'b1; rd_tid = 2'd0; br_mask = 3'b111;
        tick();
        rst = 1'b0;
        #1;
        for (int t = 0; t < 4; t++) begin
            rd_tid = 2'(t);
            #1;
            vectors++;
            if (nzp !== 3'b000 || cc_valid !== 1'b0 || br_taken !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_ctx%0d: nzp=%b valid=%b taken=%b, required 000/0/0", t, nzp, cc_valid, br_taken);
            end
        end
        vectors++;
        if (taken_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_cnt: got %h, required 0000", taken_cnt);
        end
        br_eval = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_reduction();
        logic [15:0] data_v [4];
        logic [2:0]  exp_v  [4];
        data_v[0] = 16'h8000; exp_v[0] = 3'b100;
        data_v[1] = 16'h0000; exp_v[1] = 3'b010;
        data_v[2] = 16'h7FFF; exp_v[2] = 3'b001;
        data_v[3] = 16'hFFFF; exp_v[3] = 3'b100;
        gwe = 1'b1; rd_tid = 2'd0;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_tid = 2'd0; wr_data = data_v[i];
            tick();
            wr_en = 1'b0;
            #1;
            vectors++;
            if (nzp !== exp_v[i] || cc_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL reduce_%h: nzp=%b valid=%b, required %b/1", data_v[i], nzp, cc_valid, exp_v[i]);
            end
        end
    endtask

    task automatic test_isolation();
        gwe = 1'b1; wr_en = 1'b1;
        wr_tid = 2'd1; wr_data = 16'd5;
        tick();
        wr_tid = 2'd2; wr_data = 16'hFFFD;
        tick();
        wr_en = 1'b0;
        rd_tid = 2'd1; #1;
        vectors++;
        if (nzp !== 3'b001) begin
            miscompares++;
            $display("FAIL iso_tid1: nzp=%b, required 001", nzp);
        end
        rd_tid = 2'd2; #1;
        vectors++;
        if (nzp !== 3'b100) begin
            miscompares++;
            $display("FAIL iso_tid2: nzp=%b, required 100", nzp);
        end
        rd_tid = 2'd0; #1;
        vectors++;
        if (nzp !== 3'b100) begin
            miscompares++;
            $display("FAIL iso_tid0: nzp=%b, required 100", nzp);
        end
        rd_tid = 2'd3; br_mask = 3'b111; br_eval = 1'b1; #1;
        vectors++;
        if (cc_valid !== 1'b0 || br_taken !== 1'b0 || nzp !== 3'b000) begin
            miscompares++;
            $display("FAIL iso_tid3: valid=%b taken=%b nzp=%b, required 0/0/000", cc_valid, br_taken, nzp);
        end
        br_eval = 1'b0;
    endtask

    task automatic test_gating();
        gwe = 1'b0; wr_en = 1'b1; wr_tid = 2'd0; wr_data = 16'h0000;
        tick();
        wr_en = 1'b0; rd_tid = 2'd0; #1;
        vectors++;
        if (nzp !== 3'b100) begin
            miscompares++;
            $display("FAIL gate_write: nzp=%b, required 100", nzp);
        end
        br_eval = 1'b1; br_mask = 3'b100; #1;
        vectors++;
        if (br_taken !== 1'b1) begin
            miscompares++;
            $display("FAIL gate_taken_comb: taken=%b, required 1", br_taken);
        end
        tick();
        vectors++;
        if (taken_cnt !== 16'(exp_cnt)) begin
            miscompares++;
            $display("FAIL gate_cnt_hold: got %0d, required %0d", taken_cnt, exp_cnt);
        end
        gwe = 1'b1;
        tick();
        exp_cnt++;
        br_eval = 1'b0;
        vectors++;
        if (taken_cnt !== 16'(exp_cnt)) begin
            miscompares++;
            $display("FAIL gate_cnt_inc: got %0d, required %0d", taken_cnt, exp_cnt);
        end
    endtask

    task automatic test_same_cycle();
        gwe = 1'b1; wr_en = 1'b1; wr_tid = 2'd0; wr_data = 16'd1;
        tick();
        wr_data = 16'h0000; rd_tid = 2'd0; br_eval = 1'b1; br_mask = 3'b010; #1;
`ifdef LC4_NZP_CC_BYPASS_EN
        vectors++;
        if (br_taken !== 1'b1 || nzp !== 3'b010) begin
            miscompares++;
            $display("FAIL same_cycle_bypass: taken=%b nzp=%b, required 1/010", br_taken, nzp);
        end
        exp_cnt++;
`else
        vectors++;
        if (br_taken !== 1'b0 || nzp !== 3'b001) begin
            miscompares++;
            $display("FAIL same_cycle_old: taken=%b nzp=%b, required 0/001", br_taken, nzp);
        end
`endif
        tick();
        wr_en = 1'b0; #1;
        vectors++;
        if (br_taken !== 1'b1 || nzp !== 3'b010) begin
            miscompares++;
            $display("FAIL same_cycle_next: taken=%b nzp=%b, required 1/010", br_taken, nzp);
        end
        vectors++;
        if (taken_cnt !== 16'(exp_cnt)) begin
            miscompares++;
            $display("FAIL same_cycle_cnt: got %0d, required %0d", taken_cnt, exp_cnt);
        end
        br_eval = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] data_v [4];
        logic [2:0]  exp_v  [4];
        data_v[0] = 16'h0001; exp_v[0] = 3'b001;
        data_v[1] = 16'h0000; exp_v[1] = 3'b010;
        data_v[2] = 16'hC000; exp_v[2] = 3'b100;
        data_v[3] = 16'h4000; exp_v[3] = 3'b001;
        gwe = 1'b1; wr_en = 1'b1;
        for (int t = 0; t < 4; t++) begin
            wr_tid = 2'(t); wr_data = data_v[t];
            tick();
        end
        wr_en = 1'b0;
        for (int t = 0; t < 4; t++) begin
            rd_tid = 2'(t); #1;
            vectors++;
            if (nzp !== exp_v[t] || cc_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_tid%0d: nzp=%b valid=%b, required %b/1", t, nzp, cc_valid, exp_v[t]);
            end
        end
    endtask

    task automatic test_saturation();
        gwe = 1'b1; wr_en = 1'b0; rd_tid = 2'd1; br_mask = 3'b010; br_eval = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        exp_cnt = exp_cnt + 100;
        vectors++;
        if (taken_cnt !== 16'(exp_cnt)) begin
            miscompares++;
            $display("FAIL sat_partial: got %0d, required %0d", taken_cnt, exp_cnt);
        end
        for (int i = 0; i < 65440; i++) tick();
        vectors++;
        if (taken_cnt !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL sat_limit: got %h, required ffff", taken_cnt);
        end
        for (int i = 0; i < 3; i++) tick();
        vectors++;
        if (taken_cnt !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL sat_hold: got %h, required ffff", taken_cnt);
        end
        br_eval = 1'b0;
    endtask

    task automatic test_reset_mid();
        gwe = 1'b1; wr_en = 1'b1; wr_tid = 2'd0; wr_data = 16'h8000;
        rd_tid = 2'd1; br_eval = 1'b1; br_mask = 3'b111; rst = 1'b1;
        tick();
        rst = 1'b0; wr_en = 1'b0;
        for (int t = 0; t < 4; t++) begin
            rd_tid = 2'(t); #1;
            vectors++;
            if (nzp !== 3'b000 || cc_valid !== 1'b0 || br_taken !== 1'b0) begin
                miscompares++;
                $display("FAIL rstmid_ctx%0d: nzp=%b valid=%b taken=%b, required 000/0/0", t, nzp, cc_valid, br_taken);
            end
        end
        vectors++;
        if (taken_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL rstmid_cnt: got %h, required 0000", taken_cnt);
        end
        tick();
        vectors++;
        if (taken_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL rstmid_cnt_after: got %h, required 0000", taken_cnt);
        end
        br_eval = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        exp_cnt = 0;
        test_reset();
        test_reduction();
        test_isolation();
        test_gating();
        test_same_cycle();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
